// File: rtl/pipe_sel_mux.sv
// N-way WIDTH-bit channel selector followed by a DEPTH-stage registered pipeline
// with stall/flush, carrying a valid bit and an out-of-range select flag per stage.
module pipe_sel_mux #(
  parameter int unsigned     WIDTH     = 32,
  parameter int unsigned     N         = 4,
  parameter int unsigned     SEL_W     = 2,
  parameter int unsigned     DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic                 in_valid,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 stall,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic                 sel_err
);

  logic [WIDTH-1:0] pick_c;
  logic             hit_c;
  logic             err_c;

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] err_q;

  // Front-end select; an unmatched index falls back to RESET_VAL.
  always_comb begin
    pick_c = RESET_VAL;
    hit_c  = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      if (sel == SEL_W'(k)) begin
        pick_c = in_data[k*WIDTH +: WIDTH];
        hit_c  = 1'b1;
      end
    end
    err_c = in_valid & ~hit_c;
  end

  // Stage 0 captures the selected item.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      data_q[0]  <= RESET_VAL;
      valid_q[0] <= 1'b0;
      err_q[0]   <= 1'b0;
    end else if (!stall) begin
      data_q[0]  <= pick_c;
      valid_q[0] <= in_valid;
      err_q[0]   <= err_c;
    end
  end

  // Later stages shift the previous stage forward under the same control.
  for (genvar g = 1; g < int'(DEPTH); g++) begin : g_stage
    always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
        data_q[g]  <= RESET_VAL;
        valid_q[g] <= 1'b0;
        err_q[g]   <= 1'b0;
      end else if (!stall) begin
        data_q[g]  <= data_q[g-1];
        valid_q[g] <= valid_q[g-1];
        err_q[g]   <= err_q[g-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];
  assign sel_err   = err_q[DEPTH-1];

endmodule

// File: doc/pipe_sel_mux.md
# pipe_sel_mux

Parametrised N-way, WIDTH-bit operand/result selector with a DEPTH-stage registered output pipeline. It carries stall and flush and propagates a valid bit and a select-error flag alongside the data. It is used in the CPU datapath wherever a plain 2:1 combinational select must become a pipelined, hazard-aware select. Typical uses are ALU operand forwarding, write-back result merge and next-PC source.

## Interface
- WIDTH, 32, data width of every channel and of the output.
- N, 4, number of input channels; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N.
- DEPTH, 1, number of register stages between the select and the output; legal range 1..4.
- RESET_VAL, 0, WIDTH-bit value loaded into data registers on reset and flush, and for an out-of-range select.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_data  input  N*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  1  qualifies the stage-0 capture.
- sel  input  SEL_W  channel index, sampled in the same cycle as in_data.
- stall  input  1  freezes every pipeline stage.
- flush  input  1  invalidates every pipeline stage.
- out_data  output  WIDTH  data at stage DEPTH-1.
- out_valid  output  1  valid at stage DEPTH-1.
- sel_err  output  1  out-of-range select flag at stage DEPTH-1.

## Operation
- Combinational front end:
  - If sel < N, pick = in_data[sel*WIDTH +: WIDTH].
  - If sel >= N, pick = RESET_VAL and err = in_valid; otherwise err = 0.
- Stage i holds the triple {data_i, valid_i, err_i}, for i = 0..DEPTH-1.
- Priority per rising edge is reset > flush > stall > advance:
  - Reset (rst_n = 0): every data_i = RESET_VAL, valid_i = 0, err_i = 0.
  - Flush (flush = 1, rst_n = 1): every stage takes the reset values. Flush overrides stall. The current input is discarded.
  - Stall (stall = 1, flush = 0): every stage holds; the input is not captured.
  - Advance (otherwise): stage 0 <= {pick, in_valid, err}, and stage i <= stage i-1 for i >= 1.
- Invalid capture: when in_valid = 0, stage 0 still loads pick as its data. Downstream logic must ignore data whenever valid = 0.
- Outputs: out_data = data_{DEPTH-1}, out_valid = valid_{DEPTH-1}, sel_err = err_{DEPTH-1}. All outputs are registered only; there is no combinational path from input to output.
- Out-of-range select: an out-of-range sel with in_valid = 1 still produces out_valid = 1 with out_data = RESET_VAL and sel_err = 1. The item is not dropped.
- Widths: there is no arithmetic. Select comparison is unsigned on SEL_W bits.

## Timing
- Latency is DEPTH cycles from capture edge to output, excluding stalled cycles. Throughput is 1 item per non-stalled cycle.
- Reset values: out_data = RESET_VAL, out_valid = 0, sel_err = 0. These are visible from the first edge with rst_n = 0.
- Stall: outputs are bit-for-bit constant for the whole stall, for any stall length. Advance resumes on the first edge with stall = 0.
- Flush: out_valid = 0 from the edge after flush is sampled. Items in flight are lost and no partial pipeline survives. An item presented in the flush cycle is lost.
- Simultaneous stall + flush: flush wins.
- Reset during stall or flush: reset wins.
- Back-to-back items: with DEPTH = 2, items A, B, C on cycles t, t+1, t+2 appear on out_data at t+2, t+3, t+4.

## Test plan
- Reset, basic select (WIDTH=32, N=4, DEPTH=1):
  - Stimulus: hold rst_n = 0 for 2 cycles, then release. Present channels 0x11111111, 0x22222222, 0x33333333, 0x44444444 with sel = 2 and in_valid = 1.
  - Required: outputs are 0/0/0 during reset, then out_data = 0x33333333 and out_valid = 1 one cycle later.
- Select sweep, DEPTH=3:
  - Stimulus: sel = 0, 1, 2, 3 on consecutive cycles.
  - Required: out_data = 0x11111111, 0x22222222, 0x33333333, 0x44444444 on cycles t+3..t+6.
- Stall hold, DEPTH=2:
  - Stimulus: stream sel = 0, 1, 2, 3 and assert stall for 3 cycles after the second capture.
  - Required: outputs are frozen for 3 cycles; the order is preserved with no duplicates and no losses.
- Flush vs stall:
  - Stimulus: DEPTH=3 pipeline full of valid items; assert stall = 1 and flush = 1 in the same cycle.
  - Required: out_valid = 0 next cycle and stays 0 until new valid items traverse 3 stages.
- Out-of-range select:
  - Stimulus: N=3, SEL_W=2, RESET_VAL=0xDEADBEEF, sel = 3, in_valid = 1.
  - Required: out_data = 0xDEADBEEF, out_valid = 1, sel_err = 1.
  - Stimulus: same with in_valid = 0.
  - Required: sel_err = 0.
- Mid-operation reset:
  - Stimulus: pull rst_n low for 1 cycle while the pipeline is full and stalled.
  - Required: all outputs return to reset values on that edge.
